// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush control slice: FSM states,
// stall-cause codes and the architectural register-index width.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_INIT     = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN      = 2'd1;
    localparam logic [ST_W-1:0] ST_REDIRECT = 2'd2;

    localparam int unsigned CAUSE_W = 2;
    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_LOADUSE = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_MEM     = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_REDIR   = 2'b11;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the S2 source operands and the S3 load
// destination; register 0 never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    output logic                 hazard
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_live = ex_is_load && (ex_rd != '0);
    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard  = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Outputs are zero-latency decodes of
// state and inputs. Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255,
    parameter int unsigned WAIT_W           = 8
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W           = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 en_s1_s2,
    output logic                 en_s2_s3,
    output logic                 en_s3_s4,
    output logic                 en_s4_s5,
    output logic                 flush_s1_s2,
    output logic                 flush_s2_s3,
    output logic                 flush_s3_s4,
    output logic                 flush_s4_s5,
    output logic [CAUSE_W-1:0]   stall_cause,
    output logic                 timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]    perf_stall_cycles,
    output logic [PERF_W-1:0]    perf_flush_events
`endif
);

    localparam int unsigned BUB_W = 3;
    localparam logic [BUB_W-1:0]  BUBBLES   = BUB_W'(REDIRECT_BUBBLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(MEM_TIMEOUT);

    logic [ST_W-1:0]   fsm_q,   fsm_nxt;
    logic [BUB_W-1:0]  bub_q,   bub_nxt;
    logic [WAIT_W-1:0] wait_q,  wait_nxt;
    logic              terr_q,  terr_nxt;
    logic              load_use;
    logic              mem_stall;
    logic              branch_event;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .hazard      (load_use)
    );

    assign mem_stall   = mem_req && !mem_ready;
    assign timeout_err = terr_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= ST_INIT;
            bub_q  <= '0;
            wait_q <= '0;
            terr_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_nxt;
            bub_q  <= bub_nxt;
            wait_q <= wait_nxt;
            terr_q <= terr_nxt;
        end
    end

    // Priority decode: init > mem stall > branch > load-use > redirect bubble > run
    always_comb begin
        pc_en        = 1'b1;
        en_s1_s2     = 1'b1;
        en_s2_s3     = 1'b1;
        en_s3_s4     = 1'b1;
        en_s4_s5     = 1'b1;
        flush_s1_s2  = 1'b0;
        flush_s2_s3  = 1'b0;
        flush_s3_s4  = 1'b0;
        flush_s4_s5  = 1'b0;
        stall_cause  = CAUSE_NONE;
        fsm_nxt      = fsm_q;
        bub_nxt      = bub_q;
        wait_nxt     = '0;
        terr_nxt     = terr_q;
        branch_event = 1'b0;

        if (fsm_q == ST_INIT) begin
            pc_en       = 1'b0;
            en_s1_s2    = 1'b0;
            en_s2_s3    = 1'b0;
            en_s3_s4    = 1'b0;
            en_s4_s5    = 1'b0;
            flush_s1_s2 = 1'b1;
            flush_s2_s3 = 1'b1;
            flush_s3_s4 = 1'b1;
            flush_s4_s5 = 1'b1;
            stall_cause = CAUSE_REDIR;
            fsm_nxt     = ST_RUN;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            en_s1_s2    = 1'b0;
            en_s2_s3    = 1'b0;
            en_s3_s4    = 1'b0;
            en_s4_s5    = 1'b0;
            flush_s4_s5 = 1'b1;
            stall_cause = CAUSE_MEM;
            wait_nxt    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
            if (wait_q == WAIT_TRIP) begin
                terr_nxt = 1'b1;
            end
        end else if (branch_taken) begin
            flush_s1_s2  = 1'b1;
            flush_s2_s3  = 1'b1;
            stall_cause  = CAUSE_REDIR;
            branch_event = 1'b1;
            if (BUBBLES != '0) begin
                fsm_nxt = ST_REDIRECT;
                bub_nxt = BUBBLES;
            end
        end else if (load_use && (fsm_q == ST_RUN)) begin
            // S2 in REDIRECT is a flushed bubble, so only RUN can see a real dependency
            pc_en       = 1'b0;
            en_s1_s2    = 1'b0;
            en_s2_s3    = 1'b0;
            flush_s2_s3 = 1'b1;
            stall_cause = CAUSE_LOADUSE;
        end else if (fsm_q == ST_REDIRECT) begin
            flush_s1_s2 = 1'b1;
            stall_cause = CAUSE_REDIR;
            bub_nxt     = bub_q - BUB_W'(1);
            if (bub_q == BUB_W'(1)) begin
                fsm_nxt = ST_RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters, wrap modulo 2^PERF_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if ((stall_cause == CAUSE_LOADUSE) || (stall_cause == CAUSE_MEM)) begin
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            end
            if (branch_event) begin
                perf_flush_events <= perf_flush_events + PERF_W'(1);
            end
        end
    end
`endif

endmodule
